c432_key_query_ctrl: RTL

C432_KEY_QUERY_CTRL -- requirements
Module: c432_key_query_ctrl

---
 rtl/c432_key_query_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/c432_key_query_ctrl.sv
`default_nettype none
// ============================================================================
// Module : c432_key_query_ctrl
// Brief  : Serial key loader and query sequencer for a locked c432 circuit.
// Rev    : 1.0 - initial release
// ============================================================================
module c432_key_query_ctrl #(
   parameter int KEY_W      = 8,
   parameter int PI_W       = 36,
   parameter int PO_W       = 7,
   parameter int SETTLE_CYC = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            key_load,
   input  logic            key_sin,
   input  logic            key_sin_vld,
   input  logic            query_valid,
   output logic            query_ready,
   input  logic [PI_W-1:0] query_pi,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [PO_W-1:0] resp_po,
   output logic [PI_W-1:0] dut_pi,
   output logic [KEY_W-1:0] dut_key,
   input  logic [PO_W-1:0] dut_po,
   output logic            key_loaded,
   output logic [15:0]     query_cnt
);

   localparam int CNT_W = $clog2(KEY_W + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      KSHIFT = 2'd1,
      SETTLE = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_bitcnt;
   logic [KEY_W-1:0]  r_shadow;
   logic [7:0]        r_settle;
   logic [KEY_W-1:0]  r_key;
   logic [PI_W-1:0]   r_pi;
   logic [PO_W-1:0]   r_po;
   logic              r_key_loaded;
   logic [15:0]       r_qcnt;

   logic              w_qhs;
   logic              w_shift;
   logic              w_last;
   logic              w_settle_done;
   logic [KEY_W-1:0]  w_shift_val;

   assign query_ready   = (r_state == IDLE) & r_key_loaded & ~key_load;
   assign w_qhs         = query_valid & query_ready;
   assign w_shift       = (r_state == KSHIFT) & ~key_load & key_sin_vld;
   assign w_last        = w_shift & (r_bitcnt == CNT_W'(KEY_W - 1));
   assign w_settle_done = (r_state == SETTLE) & (r_settle == 8'd0);
   // New bits enter at the MSB so the first bit ends up in bit 0 after KEY_W shifts.
   assign w_shift_val   = (r_shadow >> 1) | (KEY_W'(key_sin) << (KEY_W - 1));

   assign resp_valid = (r_state == RESP);
   assign resp_po    = r_po;
   assign dut_pi     = r_pi;
   assign dut_key    = r_key;
   assign key_loaded = r_key_loaded;
   assign query_cnt  = r_qcnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (key_load)   w_state_nxt = KSHIFT;
            else if (w_qhs) w_state_nxt = SETTLE;
         end
         KSHIFT:  if (w_last)        w_state_nxt = IDLE;
         SETTLE:  if (w_settle_done) w_state_nxt = RESP;
         RESP:    if (resp_ready)    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bitcnt     <= '0;
         r_shadow     <= '0;
         r_settle     <= '0;
         r_key        <= '0;
         r_pi         <= '0;
         r_po         <= '0;
         r_key_loaded <= 1'b0;
         r_qcnt       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (key_load) begin
                  r_bitcnt     <= '0;
                  r_shadow     <= '0;
                  r_key_loaded <= 1'b0;
               end else if (w_qhs) begin
                  r_pi     <= query_pi;
                  r_settle <= 8'(SETTLE_CYC - 1);
               end
            end
            KSHIFT: begin
               if (key_load) begin
                  r_bitcnt <= '0;
                  r_shadow <= '0;
               end else if (w_last) begin
                  r_key        <= w_shift_val;
                  r_key_loaded <= 1'b1;
                  r_qcnt       <= '0;
                  r_bitcnt     <= '0;
                  r_shadow     <= '0;
               end else if (w_shift) begin
                  r_shadow <= w_shift_val;
                  r_bitcnt <= r_bitcnt + CNT_W'(1);
               end
            end
            SETTLE: begin
               if (w_settle_done) r_po     <= dut_po;
               else               r_settle <= r_settle - 8'd1;
            end
            RESP: begin
               if (resp_ready && r_qcnt != 16'hFFFF) r_qcnt <= r_qcnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
